// File: rtl/aes_decipher_block_pkg.sv
// Shared AES decipher definitions: key-length and round constants, FSM encoding, GF(2^8) helpers.
// Optional build macro used by the core: AES_DEC_PARALLEL_SBOX_EN.
package aes_decipher_block_pkg;

  localparam logic       AES_128_BIT_KEY = 1'b0;
  localparam logic       AES_256_BIT_KEY = 1'b1;
  localparam logic [3:0] AES128_ROUNDS   = 4'd10;
  localparam logic [3:0] AES256_ROUNDS   = 4'd14;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_INIT = 2'd1,
    CTRL_SBOX = 2'd2,
    CTRL_MAIN = 2'd3
  } dec_ctrl_t;

  typedef struct packed {
    dec_ctrl_t  state;
    logic       keylen;
    logic [1:0] sword_ctr;
  } dec_dbg_t;

  function automatic logic [3:0] num_rounds(input logic keylen);
    return (keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  endfunction

  // Multiply by x modulo 0x11b.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Bus between the AES core wrapper (master, which also owns the key memory) and the decipher block.
interface aes_decipher_block_if;
  import aes_decipher_block_pkg::*;

  // Handshake: next is a one-cycle request honoured only while ready=1 (IDLE); new_block is
  // valid only while ready=1; round_key must be the key for round in the same cycle.
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;
  dec_dbg_t     dbg;

  modport master (
    output next, keylen, round_key, block,
    input  round, new_block, ready, dbg
  );

  modport slave (
    input  next, keylen, round_key, block,
    output round, new_block, ready, dbg
  );

endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational inverse S-box for one 32-bit word (four independent byte lookups).
module aes_inv_sbox (
  input  logic [31:0] sword,
  output logic [31:0] new_sword
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign new_sword = {INV_SBOX[sword[31:24]], INV_SBOX[sword[23:16]],
                      INV_SBOX[sword[15:8]],  INV_SBOX[sword[7:0]]};

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 block decipher; round counter walks Nr..0 against an external key memory.
// AES_DEC_PARALLEL_SBOX_EN: four inverse S-boxes and a one-cycle SBOX state instead of a shared one.
module aes_decipher_block
  import aes_decipher_block_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  aes_decipher_block_if.slave  bus
);

  dec_ctrl_t    dec_ctrl_reg, dec_ctrl_new;
  logic [31:0]  block_w_reg [4];
  logic [31:0]  block_w_new [4];
  logic [3:0]   block_w_we;
  logic [3:0]   round_ctr_reg;
  logic         keylen_reg;
  logic         ready_reg;

  logic         init_load, sbox_upd, main_upd, final_upd;
  logic         round_set, round_dec, ready_set, ready_clr;
  logic [127:0] state_vec, add_in, add_out, shifted;

`ifdef AES_DEC_PARALLEL_SBOX_EN
  logic [31:0]  sbox_out [4];
`else
  logic [1:0]   sword_ctr_reg;
  logic         sword_rst, sword_inc;
  logic [31:0]  sbox_in, sbox_out;
`endif

  function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    {b0, b1, b2, b3} = w;
    return {gm0e(b0) ^ gm0b(b1) ^ gm0d(b2) ^ gm09(b3),
            gm09(b0) ^ gm0e(b1) ^ gm0b(b2) ^ gm0d(b3),
            gm0d(b0) ^ gm09(b1) ^ gm0e(b2) ^ gm0b(b3),
            gm0b(b0) ^ gm0d(b1) ^ gm09(b2) ^ gm0e(b3)};
  endfunction

  // Row r of each column comes from column (c - r) mod 4, i.e. row r rotated right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++)
        r[127 - 8*(4*c + row) -: 8] = d[127 - 8*(4*((c + 4 - row) % 4) + row) -: 8];
    return r;
  endfunction

  assign state_vec = {block_w_reg[0], block_w_reg[1], block_w_reg[2], block_w_reg[3]};
  assign add_in    = init_load ? bus.block : state_vec;
  assign add_out   = add_in ^ bus.round_key;
  assign shifted   = inv_shift_rows(init_load ? add_out
                                              : {inv_mix_word(add_out[127:96]), inv_mix_word(add_out[95:64]),
                                                 inv_mix_word(add_out[63:32]),  inv_mix_word(add_out[31:0])});

`ifdef AES_DEC_PARALLEL_SBOX_EN
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (.sword(block_w_reg[g]), .new_sword(sbox_out[g]));
  end
`else
  assign sbox_in = block_w_reg[sword_ctr_reg];
  aes_inv_sbox u_inv_sbox (.sword(sbox_in), .new_sword(sbox_out));
`endif

  always_comb begin
    block_w_we = 4'b0000;
    for (int i = 0; i < 4; i++) block_w_new[i] = 32'h0;
    if (init_load || main_upd) begin
      block_w_we = 4'b1111;
      for (int i = 0; i < 4; i++) block_w_new[i] = shifted[127 - 32*i -: 32];
    end else if (final_upd) begin
      block_w_we = 4'b1111;
      for (int i = 0; i < 4; i++) block_w_new[i] = add_out[127 - 32*i -: 32];
    end else if (sbox_upd) begin
`ifdef AES_DEC_PARALLEL_SBOX_EN
      block_w_we = 4'b1111;
      for (int i = 0; i < 4; i++) block_w_new[i] = sbox_out[i];
`else
      block_w_we[sword_ctr_reg]  = 1'b1;
      block_w_new[sword_ctr_reg] = sbox_out;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) block_w_reg[i] <= 32'h0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (block_w_we[i]) block_w_reg[i] <= block_w_new[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_ctr_reg <= 4'd0;
      keylen_reg    <= 1'b0;
      ready_reg     <= 1'b1;
    end else begin
      if (round_set) begin
        round_ctr_reg <= num_rounds(bus.keylen);
        keylen_reg    <= bus.keylen;
      end else if (round_dec) begin
        round_ctr_reg <= round_ctr_reg - 4'd1;
      end
      if (ready_clr)      ready_reg <= 1'b0;
      else if (ready_set) ready_reg <= 1'b1;
    end
  end

`ifndef AES_DEC_PARALLEL_SBOX_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       sword_ctr_reg <= 2'd0;
    else if (sword_rst) sword_ctr_reg <= 2'd0;
    else if (sword_inc) sword_ctr_reg <= sword_ctr_reg + 2'd1;
  end
`endif

  // FSM: state register, next-state logic, control outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dec_ctrl_reg <= CTRL_IDLE;
    else          dec_ctrl_reg <= dec_ctrl_new;
  end

  always_comb begin
    dec_ctrl_new = dec_ctrl_reg;
    case (dec_ctrl_reg)
      CTRL_IDLE: if (bus.next) dec_ctrl_new = CTRL_INIT;
      CTRL_INIT: dec_ctrl_new = CTRL_SBOX;
`ifdef AES_DEC_PARALLEL_SBOX_EN
      CTRL_SBOX: dec_ctrl_new = CTRL_MAIN;
`else
      CTRL_SBOX: if (sword_ctr_reg == 2'd3) dec_ctrl_new = CTRL_MAIN;
`endif
      CTRL_MAIN: dec_ctrl_new = (round_ctr_reg == 4'd0) ? CTRL_IDLE : CTRL_SBOX;
      default:   dec_ctrl_new = CTRL_IDLE;
    endcase
  end

  always_comb begin
    init_load = 1'b0;
    sbox_upd  = 1'b0;
    main_upd  = 1'b0;
    final_upd = 1'b0;
    round_set = 1'b0;
    round_dec = 1'b0;
    ready_set = 1'b0;
    ready_clr = 1'b0;
`ifndef AES_DEC_PARALLEL_SBOX_EN
    sword_rst = 1'b0;
    sword_inc = 1'b0;
`endif
    case (dec_ctrl_reg)
      CTRL_IDLE: begin
        round_set = bus.next;
        ready_clr = bus.next;
      end
      CTRL_INIT: begin
        init_load = 1'b1;
        round_dec = 1'b1;
`ifndef AES_DEC_PARALLEL_SBOX_EN
        sword_rst = 1'b1;
`endif
      end
      CTRL_SBOX: begin
        sbox_upd = 1'b1;
`ifndef AES_DEC_PARALLEL_SBOX_EN
        sword_inc = 1'b1;
`endif
      end
      CTRL_MAIN: begin
        if (round_ctr_reg != 4'd0) begin
          main_upd  = 1'b1;
          round_dec = 1'b1;
`ifndef AES_DEC_PARALLEL_SBOX_EN
          sword_rst = 1'b1;
`endif
        end else begin
          final_upd = 1'b1;
          ready_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign bus.round     = round_ctr_reg;
  assign bus.new_block = state_vec;
  assign bus.ready     = ready_reg;
`ifdef AES_DEC_PARALLEL_SBOX_EN
  assign bus.dbg       = {dec_ctrl_reg, keylen_reg, 2'd0};
`else
  assign bus.dbg       = {dec_ctrl_reg, keylen_reg, sword_ctr_reg};
`endif

endmodule

// File: tb/tb_aes_decipher_block.sv
// Self-checking bench for aes_decipher_block: FIPS-197 vectors, corner sequences, random blocks vs a byte-level model.
// Honours AES_DEC_PARALLEL_SBOX_EN for the expected latency.
module tb_aes_decipher_block;
  import aes_decipher_block_pkg::*;

`ifdef AES_DEC_PARALLEL_SBOX_EN
  localparam int SB_CYC = 1;
  localparam int RST_AT = 10;
`else
  localparam int SB_CYC = 4;
  localparam int RST_AT = 30;
`endif

  typedef struct {
    logic         kl;
    logic [255:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  logic clk;
  logic reset_n;
  aes_decipher_block_if bus();

  aes_decipher_block dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int           total = 0;
  int           bad   = 0;
  logic [127:0] exp_q [$];
  logic [127:0] last_result;
  logic [127:0] rk_mem [16];
  logic [7:0]   sbox_t [256];
  logic [7:0]   inv_sbox_t [256];
  vec_t         vecs [3];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // key memory: combinational lookup by round
  always_comb bus.round_key = rk_mem[bus.round];

  // reference model
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b};
    return d[15-k -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int n = 0; n < 254; n++) inv = gf_mul(inv, 8'(x));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x] = s;
      inv_sbox_t[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0]  rcon;
    int nk, nr;
    nk   = kl ? 8 : 4;
    nr   = kl ? 14 : 10;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp  = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon, 24'h0};
        rcon = gf_mul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        tmp = sub_word(tmp);
      end
      w[i] = w[i-nk] ^ tmp;
    end
    for (int r = 0; r <= nr; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Textbook inverse cipher on a 16-byte column-major state.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int nr);
    logic [7:0]   s [16];
    logic [7:0]   a [4];
    logic [7:0]   base [4];
    logic [7:0]   tmp, acc;
    logic [127:0] out;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int k = 0; k < 16; k++) s[k] = ct[127 - 8*k -: 8] ^ rk_mem[nr][127 - 8*k -: 8];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int r = 1; r < 4; r++)
        for (int n = 0; n < r; n++) begin
          tmp = s[12 + r];
          for (int c = 3; c > 0; c--) s[4*c + r] = s[4*(c-1) + r];
          s[r] = tmp;
        end
      for (int k = 0; k < 16; k++) s[k] = inv_sbox_t[s[k]];
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk_mem[rnd][127 - 8*k -: 8];
      if (rnd > 0)
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) a[j] = s[4*c + j];
          for (int i = 0; i < 4; i++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(base[(j - i + 4) % 4], a[j]);
            s[4*c + i] = acc;
          end
        end
    end
    for (int k = 0; k < 16; k++) out[127 - 8*k -: 8] = s[k];
    return out;
  endfunction

  // scoreboard helpers
  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_num(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver: mode 0 plain, 1 = spurious next/keylen mid-run, 2 = reset at RST_AT
  task automatic run_op(input logic kl, input logic [127:0] ct, input logic [127:0] exp_pt,
                        input int mode, input int idle);
    int           nr, lat;
    logic [3:0]   seen [$];
    int           seq_ok;
    logic [127:0] exp;
    nr = (kl == AES_256_BIT_KEY) ? 14 : 10;
    repeat (idle) @(negedge clk);
    exp_q.push_back(exp_pt);
    bus.keylen = kl;
    bus.block  = ct;
    bus.next   = 1'b1;
    @(posedge clk);
    #1 bus.next = 1'b0;
    @(negedge clk);
    check_vec("hold_prev", bus.new_block, last_result);
    check_num("keylen_latch", int'(bus.dbg.keylen), int'(kl));
    lat = 0;
    while (bus.ready !== 1'b1 && lat < 400) begin
      if (seen.size() == 0 || seen[$] != bus.round) seen.push_back(bus.round);
      if (lat == 1) bus.block = {$urandom, $urandom, $urandom, $urandom};
      if (mode == 1 && (lat == 5 || lat == 20)) begin
        bus.next   = 1'b1;
        bus.keylen = ~bus.keylen;
      end else begin
        bus.next = 1'b0;
      end
      if (mode == 2 && lat == RST_AT) begin
        bus.next = 1'b0;
        reset_n  = 1'b0;
        #1;
        check_num("rst_ready", int'(bus.ready), 1);
        check_vec("rst_block", bus.new_block, 128'h0);
        check_num("rst_round", int'(bus.round), 0);
        check_num("rst_state", int'(bus.dbg.state), int'(CTRL_IDLE));
        void'(exp_q.pop_back());
        last_result = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        return;
      end
      lat++;
      @(negedge clk);
    end
    bus.next = 1'b0;
    check_num("latency", lat, 1 + nr * (SB_CYC + 1));
    seq_ok = (seen.size() == nr + 1) ? 1 : 0;
    for (int i = 0; i < seen.size() && seq_ok == 1; i++)
      if (int'(seen[i]) != nr - i) seq_ok = 0;
    check_num("round_seq", seq_ok, 1);
    exp = exp_q.pop_front();
    check_vec("plaintext", bus.new_block, exp);
    check_num("keylen_kept", int'(bus.dbg.keylen), int'(kl));
    last_result = exp;
  endtask

  initial begin
    logic         kl;
    logic [255:0] key;
    logic [127:0] ct;
    reset_n     = 1'b0;
    bus.next    = 1'b0;
    bus.keylen  = 1'b0;
    bus.block   = '0;
    last_result = '0;
    for (int i = 0; i < 16; i++) rk_mem[i] = '0;
    build_tables();

    vecs[0] = '{kl: AES_128_BIT_KEY, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, pt: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{kl: AES_256_BIT_KEY,
                key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                ct: 128'h8ea2b7ca516745bfeafc49904b496089, pt: 128'h00112233445566778899aabbccddeeff};
    vecs[2] = '{kl: AES_128_BIT_KEY, key: {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                ct: 128'h3925841d02dc09fbdc118597196a0b32, pt: 128'h3243f6a8885a308d313198a2e0370734};

    repeat (3) @(negedge clk);
    check_num("reset_ready", int'(bus.ready), 1);
    check_vec("reset_block", bus.new_block, 128'h0);
    check_num("reset_round", int'(bus.round), 0);
    check_num("reset_state", int'(bus.dbg.state), int'(CTRL_IDLE));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 3; i++) begin
      expand_key(vecs[i].key, vecs[i].kl);
      run_op(vecs[i].kl, vecs[i].ct, vecs[i].pt, 0, 2);
    end

    // spurious next pulses and keylen toggles mid-run
    expand_key(vecs[0].key, vecs[0].kl);
    run_op(vecs[0].kl, vecs[0].ct, vecs[0].pt, 1, 1);
    expand_key(vecs[1].key, vecs[1].kl);
    run_op(vecs[1].kl, vecs[1].ct, vecs[1].pt, 1, 1);

    // reset mid-operation, then a clean run
    expand_key(vecs[0].key, vecs[0].kl);
    run_op(vecs[0].kl, vecs[0].ct, vecs[0].pt, 2, 1);
    run_op(vecs[0].kl, vecs[0].ct, vecs[0].pt, 0, 0);

    // back-to-back: second next asserted as soon as ready is seen high
    expand_key(vecs[2].key, vecs[2].kl);
    run_op(vecs[2].kl, vecs[2].ct, vecs[2].pt, 0, 1);
    expand_key(vecs[1].key, vecs[1].kl);
    run_op(vecs[1].kl, vecs[1].ct, vecs[1].pt, 0, 0);

    // random blocks and keys against the model
    for (int n = 0; n < 8; n++) begin
      kl  = 1'($urandom_range(0, 1));
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ct  = {$urandom, $urandom, $urandom, $urandom};
      expand_key(key, kl);
      run_op(kl, ct, ref_decrypt(ct, kl ? 14 : 10), 0, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_decipher_block.md
Name: aes_decipher_block

Overview:
- Iterative AES block decipher core for AES-128 and AES-256; inverse of the encipher datapath.
- Processes one 128-bit ciphertext block per `next` command.
- Walks the round counter down from Nr to 0. The external key memory maps `round` to `round_key` combinationally, in the same cycle.
- Sits beside the encipher block under the AES core wrapper, sharing the key memory. The wrapper muxes `round`/`round_key` by the encdec mode.

Parameters:
- None. Key length is selected at run time via `keylen`.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- next  in  1  start decipher of `block`; single-cycle pulse, accepted only in IDLE
- keylen  in  1  0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); latched when `next` is accepted
- round  out  4  current round index; drives key memory address
- round_key  in  128  round key for `round`, valid in the same cycle
- block  in  128  ciphertext; sampled in the INIT cycle
- new_block  out  128  plaintext/state register, {w0,w1,w2,w3}, w0 = bits 127:96
- ready  out  1  1 = idle and new_block valid

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - During reset: new_block=0, ready=1, round=0, sword_ctr=0, keylen_reg=0, state=IDLE.
  - Reset asserted mid-operation aborts immediately to these values. No partial result is retained.
- Registers:
  - four 32-bit block words, each with its own write enable
  - round_ctr[3:0]
  - sword_ctr[1:0]
  - keylen_reg
  - ready_reg
  - dec_ctrl[1:0]
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - On next=1: round_ctr<=Nr(keylen), keylen_reg<=keylen, ready<=0, go to INIT.
  - next=0: hold.
- INIT (round=Nr):
  - block words <= InvShiftRows(block ^ round_key).
  - round_ctr--, sword_ctr<=0, go to SBOX.
  - Caller holds `block` stable for the cycle after `next`.
- SBOX:
  - Word[sword_ctr] <= InvSubWord(word[sword_ctr]); only that word's write enable is asserted.
  - sword_ctr++ each cycle.
  - At sword_ctr==3, go to MAIN (sword_ctr wraps to 0).
- MAIN:
  - If round_ctr>0: block <= InvShiftRows(InvMixColumns(state ^ round_key)); round_ctr--; sword_ctr<=0; go to SBOX.
  - If round_ctr==0: block <= state ^ round_key; ready<=1; go to IDLE. round stays 0.
- Latency from `next` edge to ready=1:
  - AES-128: 1 + 10*(4+1) = 51 cycles.
  - AES-256: 1 + 14*5 = 71 cycles.
- new_block:
  - Changes during operation; consumers use it only while ready=1.
  - Holds its value in IDLE until the next operation's INIT.
- Simultaneous/illegal events:
  - next while not IDLE is ignored.
  - keylen changes mid-operation are ignored (latched copy used).
  - next in the same cycle ready rises: the FSM is still in MAIN, so it is ignored. The caller waits until ready=1 is sampled.
- Arithmetic:
  - GF(2^8) with polynomial 0x11b.
  - InvMixColumns uses coefficients {0e,0b,0d,09}, built from xtime chains.
  - InvShiftRows rotates row r right by r.

Optional Feature:
- Macro: AES_DEC_PARALLEL_SBOX_EN.
- Defined:
  - Four aes_inv_sbox instances; SBOX state lasts one cycle, updating all four words.
  - sword_ctr is removed.
  - Latency: AES-128 21 cycles, AES-256 29 cycles.
- Undefined:
  - One shared aes_inv_sbox; 4-cycle SBOX as above.
- Ports and results are identical in both builds.

Decomposition:
- Shared constants header aes_defs: AES_128_BIT_KEY=0, AES_256_BIT_KEY=1, AES128_ROUNDS=10, AES256_ROUNDS=14, and the FSM state encodings.
- GF helper functions (gm09/0b/0d/0e) live in the shared header for reuse by the key-expansion/test code.
- Sub-module: aes_inv_sbox. Combinational, 32-bit word in and out, four 256-entry inverse S-box lookups.

Test Plan:
- AES-128, key 000102..0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> new_block 00112233445566778899aabbccddeeff; ready low exactly 51 cycles; round sequence 10,9,..,0.
- AES-256, key 000102..1f, ciphertext 8ea2b7ca516745bfeafc49904b496089 -> 00112233445566778899aabbccddeeff; ready low 71 cycles.
- Pulse next at cycles 5 and 20 of an operation, and toggle keylen mid-run -> both ignored; result and latency unchanged.
- Assert reset_n low at cycle 30 -> ready=1, new_block=0, round=0 asynchronously; then the AES-128 vector passes.
- Back-to-back: next one cycle after ready is sampled high, with two FIPS-197 ciphertexts -> both plaintexts correct; new_block holds the first result until INIT of the second.
- With AES_DEC_PARALLEL_SBOX_EN defined: rerun the first two vectors -> identical plaintexts, latency 21/29.
